mux6_rr_arbiter: RTL and testbench

MUX6_RR_ARBITER -- requirements
Module: mux6_rr_arbiter

---
 rtl/common_pkg.sv | 4 +
 rtl/mux6_rr_arbiter.sv | 116 +++++++++++
 tb/tb_mux6_rr_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared constants for the datapath blocks.
package common_pkg;
    localparam int DEFAULT_D_W = 8;
endpackage

// File: rtl/mux6_rr_arbiter.sv
// Six-way round-robin arbiter with a registered, back-pressured output stage.
// The common N:1 mux below carries the payload; arbitration never looks at data.

module common_mux #(
    parameter int N = 6,
    parameter int W = 8,
    parameter int L = $clog2(N)
) (
    input  logic [N-1:0][W-1:0] i_data,
    input  logic [L-1:0]        i_sel,
    output logic [W-1:0]        o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel == L'(i)) o_data = i_data[i];
        end
    end
endmodule

module mux6_rr_arbiter #(
    parameter int N = 6,
    parameter int W = common_pkg::DEFAULT_D_W,
    parameter int L = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        i_valid,
    input  logic [N-1:0][W-1:0] i_data,
    output logic [N-1:0]        o_ready_up,
    output logic                o_valid,
    output logic [W-1:0]        o_data,
    output logic [L-1:0]        o_src,
    input  logic                i_ready
);
    logic         o_valid_q, o_valid_d;
    logic [W-1:0] o_data_q, o_data_d;
    logic [L-1:0] o_src_q, o_src_d;
    logic [L-1:0] last_q, last_d;

    logic [L-1:0] win;
    logic [L-1:0] idx;
    logic         any_valid;
    logic         can_load;
    logic         xfer;
    logic [W-1:0] mux_data;
    int           pos;

    // Walk from the farthest candidate to the nearest so the nearest valid
    // requester after last is the one left standing.
    always_comb begin
        win       = '0;
        idx       = '0;
        pos       = 0;
        any_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            pos = int'(last_q) + k;
            if (pos >= N) pos = pos - N;
            idx = L'(pos);
            if (i_valid[idx]) begin
                win       = idx;
                any_valid = 1'b1;
            end
        end
    end

    assign can_load = !o_valid_q || i_ready;
    // Gating with rst_n keeps the upstream accept low throughout reset.
    assign xfer     = rst_n && can_load && any_valid;

    always_comb begin
        o_ready_up = '0;
        for (int i = 0; i < N; i++) begin
            o_ready_up[i] = xfer && (win == L'(i));
        end
    end

    common_mux #(.N(N), .W(W), .L(L)) u_mux (
        .i_data (i_data),
        .i_sel  (win),
        .o_data (mux_data)
    );

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_src_d   = o_src_q;
        last_d    = last_q;
        if (xfer) begin
            o_valid_d = 1'b1;
            o_data_d  = mux_data;
            o_src_d   = win;
            last_d    = win;
        end else if (o_valid_q && i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_src_q   <= '0;
            last_q    <= L'(N - 1);
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_src_q   <= o_src_d;
            last_q    <= last_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_src   = o_src_q;
endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Directed bench for mux6_rr_arbiter: rotation, wrap, stall, single requester,
// drain and asynchronous reset, with hand-computed expectations.
module tb_mux6_rr_arbiter;
    localparam int N = 6;
    localparam int W = common_pkg::DEFAULT_D_W;
    localparam int L = $clog2(N);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        i_valid;
    logic [N-1:0][W-1:0] i_data;
    logic [N-1:0]        o_ready_up;
    logic                o_valid;
    logic [W-1:0]        o_data;
    logic [L-1:0]        o_src;
    logic                i_ready;

    int n_checks = 0;
    int n_errors = 0;

    mux6_rr_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready_up (o_ready_up),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_src      (o_src),
        .i_ready    (i_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input int src, input int data);
        chk({tag, ".o_valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".o_src"},   32'(o_src),   32'(src));
        chk({tag, ".o_data"},  32'(o_data),  32'(data));
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 6'h3f;
        i_ready = 1'b1;
        for (int k = 0; k < N; k++) i_data[k] = W'(k + 'h10);

        // Reset state, with requests already pending
        tick();
        tick();
        chk("rst.ready_up", 32'(o_ready_up), 32'h0);
        chk_out("rst", 1'b0, 0, 0);

        rst_n = 1'b1;
        #1;
        chk("post_rst.o_valid", 32'(o_valid), 32'h0);

        // Full rotation from requester 0 with back-to-back beats
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("rr%0d.ready_up", c), 32'(o_ready_up), 32'(1 << (c % 6)));
            tick();
            chk_out($sformatf("rr%0d", c), 1'b1, c % 6, 'h10 + (c % 6));
        end

        // Stall with a beat held (last = 5)
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d.ready_up", c), 32'(o_ready_up), 32'h0);
            tick();
            chk_out($sformatf("stall%0d", c), 1'b1, 5, 'h15);
        end
        i_ready = 1'b1;
        #1;
        chk("unstall.ready_up", 32'(o_ready_up), 32'h01);
        tick();
        chk_out("unstall", 1'b1, 0, 'h10);

        // Bring last to 4, then wrap between 5 and 0
        i_valid = 6'b010000;
        #1;
        chk("set4.ready_up", 32'(o_ready_up), 32'h10);
        tick();
        chk_out("set4", 1'b1, 4, 'h14);
        i_valid = 6'b100001;
        #1;
        chk("wrap0.ready_up", 32'(o_ready_up), 32'h20);
        tick();
        chk_out("wrap0", 1'b1, 5, 'h15);
        #1;
        chk("wrap1.ready_up", 32'(o_ready_up), 32'h01);
        tick();
        chk_out("wrap1", 1'b1, 0, 'h10);
        #1;
        chk("wrap2.ready_up", 32'(o_ready_up), 32'h20);
        tick();
        chk_out("wrap2", 1'b1, 5, 'h15);

        // Lone requester 3, fresh payload every cycle
        i_valid = 6'b001000;
        for (int c = 0; c < 4; c++) begin
            i_data[3] = W'('h30 + c);
            #1;
            chk($sformatf("solo%0d.ready_up", c), 32'(o_ready_up), 32'h08);
            tick();
            chk_out($sformatf("solo%0d", c), 1'b1, 3, 'h30 + c);
        end
        i_data[3] = W'('h13);

        // Drain: valid drops after the pop, payload holds, priority unchanged
        i_valid = '0;
        #1;
        chk("drain.ready_up", 32'(o_ready_up), 32'h0);
        tick();
        chk_out("drain", 1'b0, 3, 'h33);
        tick();
        chk_out("idle", 1'b0, 3, 'h33);
        i_valid = 6'h3f;
        #1;
        chk("resume.ready_up", 32'(o_ready_up), 32'h10);
        tick();
        chk_out("resume", 1'b1, 4, 'h14);

        // Asynchronous reset in the middle of a stall
        i_ready = 1'b0;
        tick();
        chk_out("prerst", 1'b1, 4, 'h14);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 0, 0);
        chk("async_rst.ready_up", 32'(o_ready_up), 32'h0);
        tick();
        rst_n   = 1'b1;
        i_ready = 1'b1;
        #1;
        chk("rel.ready_up", 32'(o_ready_up), 32'h01);
        tick();
        chk_out("rel", 1'b1, 0, 'h10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
